// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
//   Bundles the hazard inputs seen by the stall/flush sequencer and the
//   stage-register controls it produces.
//
//   Hazard inputs (driven by the pipeline, master side):
//     IMEM_BUSYWAIT, DMEM_BUSYWAIT   cache misses in progress
//     ID_RS1, ID_RS2 [4:0]           source registers of the instruction in ID
//     ID_USES_RS1, ID_USES_RS2       instruction in ID really reads RS1 / RS2
//     EX_RD [4:0], EX_MEM_READ       destination / is-load of the instruction in EX
//     BRANCH_TAKEN                   EX resolved a taken branch/jump
//   Stage controls (driven by the controller, slave side):
//     PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN   stage register loads
//     IF_ID_FLUSH, ID_EX_FLUSH                          stage register loads a bubble
//     CTRL_STATE [1:0]                                  FSM state (debug)
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if;
  logic       IMEM_BUSYWAIT;
  logic       DMEM_BUSYWAIT;
  logic [4:0] ID_RS1;
  logic [4:0] ID_RS2;
  logic       ID_USES_RS1;
  logic       ID_USES_RS2;
  logic [4:0] EX_RD;
  logic       EX_MEM_READ;
  logic       BRANCH_TAKEN;

  logic       PC_EN;
  logic       IF_ID_EN;
  logic       ID_EX_EN;
  logic       EX_MEM_EN;
  logic       MEM_WB_EN;
  logic       IF_ID_FLUSH;
  logic       ID_EX_FLUSH;
  logic [1:0] CTRL_STATE;

  modport master (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
           EX_RD, EX_MEM_READ, BRANCH_TAKEN,
    input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH,
           CTRL_STATE
  );

  modport slave (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
           EX_RD, EX_MEM_READ, BRANCH_TAKEN,
    output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH,
           CTRL_STATE
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//   Central stall/flush sequencer for the 5-stage RV32 pipeline. Produces the
//   write enables and bubble controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB
//   from cache busywaits, load-use hazards and taken branches. Stage controls
//   are combinational from the registered state plus current inputs, so a
//   hazard is acted on in the cycle it appears.
//
//   Ports:
//     CLK, RESET          clock, synchronous active-high reset
//     hz (slave)          hazard inputs / stage controls, see the interface
//     STALL_CYCLES        cycles with PC_EN=0 (optional, saturating)
//     FLUSH_COUNT         serviced taken branches (optional, saturating)
//
//   Parameters:
//     REDIRECT_BUBBLES    extra IF_ID flush cycles after a taken branch, 0..3
//     CNT_W               width of the performance counters
//
//   Configuration macro: STALL_COUNTERS_EN adds the two performance counters
//   and their ports; without it there is no other behavioural difference.
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  pipeline_hazard_controller_if.slave   hz
`ifdef STALL_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]              STALL_CYCLES,
  output logic [CNT_W-1:0]              FLUSH_COUNT
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DSTALL   = 2'd1,
    REDIRECT = 2'd2,
    ISTALL   = 2'd3
  } state_t;

  localparam logic [1:0] RB_LOAD = REDIRECT_BUBBLES[1:0];

  state_t     state_reg, state_next;
  logic [1:0] redir_cnt_reg, redir_cnt_next;

  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush;
  logic       branch_fire;

  // Load-use detection: one comparator per source operand.
  logic [1:0] src_hit;
  logic [4:0] src_reg [2];
  logic [1:0] src_used;
  assign src_reg[0]  = hz.ID_RS1;
  assign src_reg[1]  = hz.ID_RS2;
  assign src_used[0] = hz.ID_USES_RS1;
  assign src_used[1] = hz.ID_USES_RS2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = src_used[gi] && (src_reg[gi] == hz.EX_RD);
    end
  endgenerate

  // x0 is never a real dependency.
  logic load_use;
  assign load_use = hz.EX_MEM_READ && (hz.EX_RD != 5'd0) && (|src_hit);

  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    state_next     = RUN;
    redir_cnt_next = redir_cnt_reg;
    branch_fire    = 1'b0;

    if (RESET) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redir_cnt_next = 2'd0;
    end else if (hz.DMEM_BUSYWAIT) begin
      // Whole pipe frozen; any pending branch/LU is simply seen again later.
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      state_next = DSTALL;
    end else if (hz.BRANCH_TAKEN) begin
      branch_fire = 1'b1;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (RB_LOAD != 2'd0) begin
        redir_cnt_next = RB_LOAD;
        state_next     = REDIRECT;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      // A load-use stall inside a redirect window just pauses the window.
      if (state_reg == REDIRECT) state_next = REDIRECT;
    end else if (state_reg == REDIRECT) begin
      // Target fetch still in flight: keep bubbling IF_ID.
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      if (hz.IMEM_BUSYWAIT) begin
        pc_en      = 1'b0;
        state_next = REDIRECT;
      end else begin
        redir_cnt_next = redir_cnt_reg - 2'd1;
        state_next     = (redir_cnt_reg > 2'd1) ? REDIRECT : RUN;
      end
    end else if (hz.IMEM_BUSYWAIT) begin
      // Downstream stages keep draining while fetch waits.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      state_next  = ISTALL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= RUN;
      redir_cnt_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      redir_cnt_reg <= redir_cnt_next;
    end
  end

  assign hz.PC_EN       = pc_en;
  assign hz.IF_ID_EN    = if_id_en;
  assign hz.ID_EX_EN    = id_ex_en;
  assign hz.EX_MEM_EN   = ex_mem_en;
  assign hz.MEM_WB_EN   = mem_wb_en;
  assign hz.IF_ID_FLUSH = if_id_flush;
  assign hz.ID_EX_FLUSH = id_ex_flush;
  assign hz.CTRL_STATE  = state_reg;

`ifdef STALL_COUNTERS_EN
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_count_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (!pc_en && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      if (branch_fire && (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + 1'b1;
    end
  end

  assign STALL_CYCLES = stall_cycles_reg;
  assign FLUSH_COUNT  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//   Directed bench for pipeline_hazard_controller (REDIRECT_BUBBLES=1).
//   Each step drives inputs just after the falling edge and compares the
//   packed control word {PC,IF_ID,ID_EX,EX_MEM,MEM_WB EN, IF_ID/ID_EX FLUSH,
//   CTRL_STATE} against a hand-computed value before the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;
  localparam int CNT_W = 32;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  pipeline_hazard_controller_if hz();

`ifdef STALL_COUNTERS_EN
  logic [CNT_W-1:0] STALL_CYCLES, FLUSH_COUNT;
`endif

  pipeline_hazard_controller #(.REDIRECT_BUBBLES(1), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .hz    (hz.slave)
`ifdef STALL_COUNTERS_EN
    ,
    .STALL_CYCLES (STALL_CYCLES),
    .FLUSH_COUNT  (FLUSH_COUNT)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  // {en[4:0], flush[1:0], state[1:0]}
  localparam logic [8:0] NORM0 = {5'b11111, 2'b00, 2'd0};

  function automatic logic [8:0] ctl_word();
    return {hz.PC_EN, hz.IF_ID_EN, hz.ID_EX_EN, hz.EX_MEM_EN, hz.MEM_WB_EN,
            hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.CTRL_STATE};
  endfunction

  // Compare the control word, then advance to the next falling edge.
  task automatic chk(input string tag, input logic [8:0] expv);
    logic [8:0] obs;
    #1;
    obs = ctl_word();
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%b required=%b", tag, obs, expv);
    end
    $display("[TB] %s ctl=%b", tag, obs);
    @(negedge CLK);
  endtask

  task automatic clr();
    hz.IMEM_BUSYWAIT = 0; hz.DMEM_BUSYWAIT = 0; hz.BRANCH_TAKEN = 0;
    hz.ID_RS1 = 0; hz.ID_RS2 = 0; hz.ID_USES_RS1 = 0; hz.ID_USES_RS2 = 0;
    hz.EX_RD = 0; hz.EX_MEM_READ = 0;
  endtask

  // EX: lw x5 ; ID: add x6,x5,x1
  task automatic set_lu();
    hz.EX_MEM_READ = 1; hz.EX_RD = 5'd5;
    hz.ID_RS1 = 5'd5; hz.ID_USES_RS1 = 1;
    hz.ID_RS2 = 5'd1; hz.ID_USES_RS2 = 1;
  endtask

  initial begin
    clr();
    RESET = 1;
    @(negedge CLK);

    // 1: reset and release
    chk("reset_c1", {5'b00000, 2'b11, 2'd0});
    chk("reset_c2", {5'b00000, 2'b11, 2'd0});
    RESET = 0;
    chk("release", NORM0);

    // 2: load-use
    set_lu();
    chk("lu_rs1", {5'b00011, 2'b01, 2'd0});
    hz.EX_MEM_READ = 0;            // load has left EX
    chk("lu_cleared", NORM0);
    hz.EX_MEM_READ = 1; hz.EX_RD = 5'd0; hz.ID_RS1 = 5'd0;
    chk("lu_x0", NORM0);
    hz.EX_RD = 5'd7; hz.ID_RS1 = 5'd3; hz.ID_RS2 = 5'd7;
    chk("lu_rs2", {5'b00011, 2'b01, 2'd0});
    hz.ID_USES_RS2 = 0;
    chk("lu_rs2_unused", NORM0);
    clr();

    // 3: taken branch with one redirect bubble
    hz.BRANCH_TAKEN = 1;
    chk("br_fire", {5'b10011, 2'b11, 2'd0});
    hz.BRANCH_TAKEN = 0;
    chk("br_redirect", {5'b10111, 2'b10, 2'd2});
    chk("br_done", NORM0);

    // redirect window held by instruction miss
    hz.BRANCH_TAKEN = 1;
    chk("br2_fire", {5'b10011, 2'b11, 2'd0});
    hz.BRANCH_TAKEN = 0; hz.IMEM_BUSYWAIT = 1;
    chk("br2_redir_busy", {5'b00111, 2'b10, 2'd2});
    hz.IMEM_BUSYWAIT = 0;
    chk("br2_redir", {5'b10111, 2'b10, 2'd2});
    chk("br2_done", NORM0);

    // 4: data miss 5 cycles with load-use pending
    set_lu(); hz.DMEM_BUSYWAIT = 1;
    chk("dmiss_c1", {5'b00000, 2'b00, 2'd0});
    for (int i = 2; i <= 5; i++)
      chk($sformatf("dmiss_c%0d", i), {5'b00000, 2'b00, 2'd1});
    hz.DMEM_BUSYWAIT = 0;
    chk("dmiss_lu", {5'b00011, 2'b01, 2'd1});
    hz.EX_MEM_READ = 0;
    chk("dmiss_after", NORM0);
    clr();

    // 5: branch together with data miss
    hz.BRANCH_TAKEN = 1; hz.DMEM_BUSYWAIT = 1;
    chk("brd_freeze1", {5'b00000, 2'b00, 2'd0});
    chk("brd_freeze2", {5'b00000, 2'b00, 2'd1});
    hz.DMEM_BUSYWAIT = 0;
    chk("brd_fire", {5'b10011, 2'b11, 2'd1});
    hz.BRANCH_TAKEN = 0;
    chk("brd_redir", {5'b10111, 2'b10, 2'd2});
    chk("brd_done", NORM0);

    // instruction miss
    hz.IMEM_BUSYWAIT = 1;
    chk("imiss_c1", {5'b00111, 2'b10, 2'd0});
    chk("imiss_c2", {5'b00111, 2'b10, 2'd3});
    hz.IMEM_BUSYWAIT = 0;
    chk("imiss_exit", {5'b11111, 2'b00, 2'd3});
    chk("imiss_run", NORM0);

`ifdef STALL_COUNTERS_EN
    // 6: counters, 4 imiss cycles + one load-use bubble
    RESET = 1;
    chk("cnt_reset", {5'b00000, 2'b11, 2'd0});
    RESET = 0;
    hz.IMEM_BUSYWAIT = 1;
    chk("cnt_im1", {5'b00111, 2'b10, 2'd0});
    for (int i = 2; i <= 4; i++)
      chk($sformatf("cnt_im%0d", i), {5'b00111, 2'b10, 2'd3});
    hz.IMEM_BUSYWAIT = 0;
    set_lu();
    chk("cnt_lu", {5'b00011, 2'b01, 2'd3});
    clr();
    #1;
    tests_run++;
    assert (STALL_CYCLES === 32'd5) else begin
      tests_failed++;
      $error("FAIL stall_cycles observed=%0d required=5", STALL_CYCLES);
    end
    tests_run++;
    assert (FLUSH_COUNT === 32'd0) else begin
      tests_failed++;
      $error("FAIL flush_count observed=%0d required=0", FLUSH_COUNT);
    end
    $display("[TB] counters stall=%0d flush=%0d", STALL_CYCLES, FLUSH_COUNT);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
